rv_div_seq: RTL

RV_DIV_SEQ -- requirements
Module: rv_div_seq

---
 rtl/pkg_rv_decode.sv | 20 ++
 rtl/rv_div_seq_if.sv | 16 +
 rtl/rv_div_step.sv | 20 ++
 rtl/rv_types.svh | 3 +
 rtl/rv_div_seq.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/pkg_rv_decode.sv
// Shared RV decode package: ALU operation codes used across execution units.
package pkg_rv_decode;
    `include "rv_types.svh"

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_MUL  = 5'd8,
        ALU_DIV  = 5'd12,
        ALU_DIVU = 5'd13,
        ALU_REM  = 5'd14,
        ALU_REMU = 5'd15
    } alu_t;
endpackage

// File: rtl/rv_div_seq_if.sv
// Request/response bundle between the issue stage and the sequential divider.
interface rv_div_seq_if;
    import pkg_rv_decode::*;

    logic start;
    logic kill;
    alu_t alu;
    u32_t rrd1;
    u32_t rrd2;
    logic busy;
    logic done;
    u32_t result;

    modport master (output start, kill, alu, rrd1, rrd2, input busy, done, result);
    modport slave  (input start, kill, alu, rrd1, rrd2, output busy, done, result);
endinterface

// File: rtl/rv_div_step.sv
// One restoring shift-subtract iteration: shifts in the next dividend bit and trial-subtracts.
module rv_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dividend_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt_c,
    output logic            q_bit_c
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted   = {rem_in, dividend_msb};
        diff      = shifted - {1'b0, divisor};
        q_bit_c   = ~diff[XLEN];
        rem_nxt_c = q_bit_c ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end
endmodule

// File: rtl/rv_types.svh
// Shared 32-bit scalar types for the RV datapath blocks.
typedef logic        [31:0] u32_t;
typedef logic signed [31:0] s32_t;

// File: rtl/rv_div_seq.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU (34-cycle latency, 1 cycle for special cases).
// Optional last-result cache enabled by defining RV_DIV_CACHE_EN.
module rv_div_seq
    import pkg_rv_decode::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         xreset,
    rv_div_seq_if.slave  bus
);
    localparam int unsigned   CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  S_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   quo, rem, dvs, result_q;
    logic [CNT_W-1:0]  cnt;
    logic              q_neg, r_neg, want_rem, busy_q, done_q;

    logic              legal_c, sgn_c, rem_op_c, a_neg_c, b_neg_c;
    logic              div0_c, ovf_c, special_c, accept_c, hit_c, q_bit_c;
    logic [XLEN-1:0]   a_mag_c, b_mag_c, special_res_c, fix_q_c, fix_r_c;
    logic [XLEN-1:0]   cache_res_c, rem_step_c;

    rv_div_step #(.XLEN(XLEN)) u_step (
        .rem_in       (rem),
        .dividend_msb (quo[XLEN-1]),
        .divisor      (dvs),
        .rem_nxt_c    (rem_step_c),
        .q_bit_c      (q_bit_c)
    );

    // Request decode, operand magnitudes and the results of the short-cut cases.
    always_comb begin
        legal_c       = bus.alu inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        sgn_c         = bus.alu inside {ALU_DIV, ALU_REM};
        rem_op_c      = bus.alu inside {ALU_REM, ALU_REMU};
        a_neg_c       = sgn_c & bus.rrd1[XLEN-1];
        b_neg_c       = sgn_c & bus.rrd2[XLEN-1];
        a_mag_c       = a_neg_c ? -bus.rrd1 : bus.rrd1;
        b_mag_c       = b_neg_c ? -bus.rrd2 : bus.rrd2;
        div0_c        = (bus.rrd2 == '0);
        ovf_c         = sgn_c && (bus.rrd1 == S_MIN) && (bus.rrd2 == '1);
        special_c     = div0_c || ovf_c;
        special_res_c = '0;
        if (div0_c)
            special_res_c = rem_op_c ? bus.rrd1 : '1;
        else if (ovf_c)
            special_res_c = rem_op_c ? '0 : S_MIN;
        accept_c      = (state == IDLE) && bus.start && !bus.kill && legal_c;
        fix_q_c       = q_neg ? -quo : quo;
        fix_r_c       = r_neg ? -rem : rem;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = (special_c || hit_c) ? DONE : CALC;
            CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Datapath: latch on accept, iterate in CALC, sign-correct in FIX.
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            want_rem <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt == CALC) || (state_nxt == FIX);
            done_q <= (state_nxt == DONE);
            case (state)
                IDLE: if (accept_c) begin
                    quo      <= a_mag_c;
                    rem      <= '0;
                    dvs      <= b_mag_c;
                    cnt      <= '0;
                    q_neg    <= a_neg_c ^ b_neg_c;
                    r_neg    <= a_neg_c;
                    want_rem <= rem_op_c;
                    if (special_c)  result_q <= special_res_c;
                    else if (hit_c) result_q <= cache_res_c;
                end
                CALC: begin
                    quo <= {quo[XLEN-2:0], q_bit_c};
                    rem <= rem_step_c;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX:     result_q <= want_rem ? fix_r_c : fix_q_c;
                default: ;
            endcase
        end
    end

`ifdef RV_DIV_CACHE_EN
    logic            c_valid, c_sgn, op_sgn;
    logic [XLEN-1:0] c_a, c_b, c_q, c_r, op_a, op_b;

    assign hit_c       = c_valid && (c_a == bus.rrd1) && (c_b == bus.rrd2) && (c_sgn == sgn_c);
    assign cache_res_c = rem_op_c ? c_r : c_q;

    // Remembers the last full-length completion so a DIV/REM pair needs only one pass.
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            c_valid <= 1'b0;
            c_sgn   <= 1'b0;
            op_sgn  <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_q     <= '0;
            c_r     <= '0;
            op_a    <= '0;
            op_b    <= '0;
        end else if (bus.kill) begin
            c_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                op_a   <= bus.rrd1;
                op_b   <= bus.rrd2;
                op_sgn <= sgn_c;
                if (special_c) c_valid <= 1'b0;
            end
            if (state == FIX) begin
                c_valid <= 1'b1;
                c_a     <= op_a;
                c_b     <= op_b;
                c_sgn   <= op_sgn;
                c_q     <= fix_q_c;
                c_r     <= fix_r_c;
            end
        end
    end
`else
    assign hit_c       = 1'b0;
    assign cache_res_c = '0;
`endif

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
